// File: rtl/mips_cpu_pkg.sv
// Shared core definitions: sub-word store opcodes and the SB/SH scheduler state encoding.
package mips_cpu_pkg;

  localparam logic [5:0] OP_SB = 6'b101000;
  localparam logic [5:0] OP_SH = 6'b101001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } sbsh_state_t;

  function automatic logic is_sub_word_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH);
  endfunction

endpackage

// File: rtl/sb_sh_scheduler_lane_merge.sv
// Combinational byte/halfword lane merge of store data into a word read back from memory.
module sbsh_lane_merge #(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic [31:0] old_word,
  input  logic [15:0] wdata,
  input  logic [1:0]  addr_lo,
  input  logic        is_half,
  output logic [31:0] merged_word
);

  logic [1:0] byte_lane;
  logic       half_lane;

  // For two bits, 3 - addr equals the bitwise inverse.
  assign byte_lane = BIG_ENDIAN ? ~addr_lo : addr_lo;
  assign half_lane = addr_lo[1] ^ BIG_ENDIAN;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] BYTE_IDX = 2'(gi);
      localparam logic       HALF_IDX = (gi >= 2);
      localparam int         SRC_LSB  = (gi % 2) * 8;
      logic hit;
      assign hit = is_half ? (half_lane == HALF_IDX) : (byte_lane == BYTE_IDX);
      assign merged_word[8*gi +: 8] = !hit    ? old_word[8*gi +: 8] :
                                      is_half ? wdata[SRC_LSB +: 8] : wdata[7:0];
    end
  endgenerate

endmodule

// File: rtl/sb_sh_scheduler.sv
// SB/SH read-modify-write scheduler for a word-only data memory port.
// Optional macro SB_SH_ALIGN_CHECK_EN rejects SH with addr[0]=1 and pulses misalign.
module sb_sh_scheduler
  import mips_cpu_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic [5:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest,
  output logic        misalign
);

  sbsh_state_t state_q, state_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [15:0] wdata_q, wdata_d;
  logic        is_half_q, is_half_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] mem_writedata_q, mem_writedata_d;

  logic        accept_window;
  logic        accept;
  logic        misalign_w;
  logic [31:0] merged_word;
  logic        unused_wdata_hi;

  assign unused_wdata_hi = ^wdata[31:16];
  assign accept_window   = (state_q == IDLE) || (state_q == DONE);

`ifdef SB_SH_ALIGN_CHECK_EN
  assign misalign_w = reset_n && accept_window && req && (op == OP_SH) && addr[0];
`else
  assign misalign_w = 1'b0;
`endif

  // reset_n gates acceptance so a held req cannot raise stall during reset.
  assign accept = reset_n && accept_window && req && is_sub_word_store(op) && !misalign_w;

  sbsh_lane_merge #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_merge (
    .old_word    (mem_readdata),
    .wdata       (wdata_q),
    .addr_lo     (addr_lo_q),
    .is_half     (is_half_q),
    .merged_word (merged_word)
  );

  always_comb begin
    state_d         = state_q;
    addr_lo_d       = addr_lo_q;
    wdata_d         = wdata_q;
    is_half_d       = is_half_q;
    busy_d          = busy_q;
    done_d          = done_q;
    mem_read_d      = mem_read_q;
    mem_write_d     = mem_write_q;
    mem_address_d   = mem_address_q;
    mem_writedata_d = mem_writedata_q;
    case (state_q)
      IDLE, DONE: begin
        done_d      = 1'b0;
        mem_write_d = 1'b0;
        if (accept) begin
          state_d       = RD;
          busy_d        = 1'b1;
          mem_read_d    = 1'b1;
          mem_address_d = {addr[31:2], 2'b00};
          addr_lo_d     = addr[1:0];
          wdata_d       = wdata[15:0];
          is_half_d     = (op == OP_SH);
        end else begin
          state_d    = IDLE;
          busy_d     = 1'b0;
          mem_read_d = 1'b0;
        end
      end
      RD: begin
        // The merged word is registered directly, so the read data is captured already merged.
        if (!mem_waitrequest) begin
          state_d         = WR;
          mem_read_d      = 1'b0;
          mem_write_d     = 1'b1;
          mem_writedata_d = merged_word;
        end
      end
      WR: begin
        if (!mem_waitrequest) begin
          state_d     = DONE;
          mem_write_d = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      addr_lo_q       <= 2'b00;
      wdata_q         <= 16'h0000;
      is_half_q       <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= 32'h0000_0000;
      mem_writedata_q <= 32'h0000_0000;
    end else begin
      state_q         <= state_d;
      addr_lo_q       <= addr_lo_d;
      wdata_q         <= wdata_d;
      is_half_q       <= is_half_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
    end
  end

  assign stall         = accept || busy_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_address   = mem_address_q;
  assign mem_writedata = mem_writedata_q;
  assign misalign      = misalign_w;

endmodule

// File: doc/sb_sh_scheduler.md
Name: sb_sh_scheduler

Overview:
Multi-cycle controller that executes SB/SH (opcodes 101000/101001) as a read-modify-write on the word-only data memory bus. The main decoder leaves both stores unasserted and routes them here. The block stalls the core, reads the aligned word, merges the byte or halfword lane, and writes the word back. It sits between the execute-stage store operands and the data-memory port, and is muxed onto that port while busy.

Parameters:
BIG_ENDIAN, 0, lane order: 0 = byte 0 at bits [7:0]; 1 = byte 0 at bits [31:24]

Ports:
clk  input  1  core clock
reset_n  input  1  reset, asynchronous, active-low
req  input  1  SB/SH present in execute; held by core while stall=1
op  input  6  opcode of the requesting instruction
addr  input  32  effective byte address
wdata  input  32  rt value; only low byte/half used
stall  output  1  freeze core pipeline
busy  output  1  owns memory port (state RD or WR)
done  output  1  one-cycle pulse, store committed
mem_address  output  32  word address {addr[31:2],2'b00}
mem_read  output  1  read strobe
mem_write  output  1  write strobe
mem_writedata  output  32  merged word
mem_readdata  input  32  read return, valid when mem_read=1 and mem_waitrequest=0
mem_waitrequest  input  1  memory not ready; hold the request
misalign  output  1  SH with addr[0]=1 (feature only; otherwise tied 0)

Behaviour:
- States: IDLE, RD, WR, DONE.
- Reset (async, reset_n=0): state=IDLE; stall, busy, done, mem_read, mem_write, misalign all 0; mem_address and mem_writedata 0.
- IDLE/DONE: req=1 with op in {SB,SH} accepts the request. It latches addr, wdata and op, then goes to RD. stall=1 combinationally in the acceptance cycle.
- A req with any other op is ignored: no stall, state unchanged.
- RD: mem_read=1, mem_address = latched word address.
  - Stay in RD while mem_waitrequest=1.
  - On mem_waitrequest=0, capture mem_readdata, go to WR.
- WR: mem_write=1, mem_writedata = merged word.
  - Stay in WR while mem_waitrequest=1.
  - Otherwise go to DONE.
- DONE: done=1, stall=0 (unless a new request is accepted in the same cycle). Next state is RD on a new accepted request, else IDLE.
- stall = (accepting in IDLE/DONE) | (state==RD) | (state==WR).
- busy = (state==RD) | (state==WR).
- mem_read and mem_write are never both 1.
- mem_address, mem_writedata and the strobes are stable while mem_waitrequest=1.
- Merge rules:
  - SB: lane = addr[1:0] (BIG_ENDIAN=1: 3-addr[1:0]); replace that byte with wdata[7:0].
  - SH: lane = addr[1] (BIG_ENDIAN=1: inverted); replace that half with wdata[15:0].
  - All other bits come from the captured read word.
- Zero-wait latency: accept at T, RD at T+1, WR at T+2, DONE at T+3. stall is high T..T+2; each wait cycle adds one.
- Reset mid-operation: a write in progress is abandoned (strobe drops immediately) and no done pulse is produced.
- Without the feature, SH ignores addr[0].

Optional Feature:
SB_SH_ALIGN_CHECK_EN
- Defined: an SH with addr[0]=1 performs no memory access. misalign pulses for 1 cycle in the acceptance cycle, stall stays 0, and state stays IDLE.
- Undefined: misalign is tied 0 and addr[0] is ignored for SH.

Decomposition:
- Shared package mips_cpu_pkg:
  - opcode constants OP_SB=6'b101000, OP_SH=6'b101001
  - state enum sbsh_state_t {IDLE,RD,WR,DONE}
- One sub-module: sbsh_lane_merge, combinational. Inputs: old word, wdata, addr[1:0], is_half, BIG_ENDIAN. Output: merged word.

Test Plan:
- SB addr=0x00001003, wdata=0x000000AB, memory 0x11223344, no waits → mem_address=0x1000; written word 0xAB223344; stall high 3 cycles; done at T+3.
- SH addr=0x00002002, wdata=0x0000BEEF, memory 0xCAFEF00D, BIG_ENDIAN=0 → written 0xBEEFF00D. Same stimulus with BIG_ENDIAN=1 → 0xCAFEBEEF.
- SB addr=0x10, mem_waitrequest high for 3 cycles in RD and 2 cycles in WR → strobes and address held; stall high 8 cycles; exactly one write.
- reset_n asserted low during WR → mem_write drops the same cycle; state IDLE; no done pulse; memory unchanged.
- Back-to-back SB then SH, with the second req present in DONE → done for the first, immediate RD for the second; stall low for zero cycles between them.
- With SB_SH_ALIGN_CHECK_EN: SH addr=0x3001 → misalign=1 for one cycle; no mem_read or mem_write; stall=0.
